// File: rtl/mux_nx1_rr.sv
// Registered N:1 valid/ready output mux, steered (mode 0) or round-robin (mode 1) grant.
// Define MUX_CNT_EN to add the 16-bit output-handshake counter on xfer_cnt.
module mux_nx1_rr #(
  parameter int W = 4,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_ch
`ifdef MUX_CNT_EN
  ,
  output logic [15:0]    xfer_cnt
`endif
);

  localparam int NP = 1 << SW;

  logic [W-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load_en_s;
  logic [NP-1:0] valid_ext_s;
  logic          sel_ok_s;
  logic          rr_found_s;
  logic [SW-1:0] rr_grant_s;
  logic          grant_valid_s;
  logic [SW-1:0] grant_s;
  logic [N-1:0]  in_ready_s;

  // Steered grant: selects beyond the last channel never grant.
  always_comb begin
    valid_ext_s = NP'(in_valid);
    if ({1'b0, s} < (SW+1)'(N)) begin
      sel_ok_s = valid_ext_s[s];
    end else begin
      sel_ok_s = 1'b0;
    end
  end

  // Round-robin scan starts just after the last granted channel and wraps.
  always_comb begin
    rr_found_s = 1'b0;
    rr_grant_s = '0;
    for (int k = 1; k <= N; k++) begin
      if (!rr_found_s && in_valid[(int'(ptr_q) + k) % N]) begin
        rr_found_s = 1'b1;
        rr_grant_s = SW'((int'(ptr_q) + k) % N);
      end else begin
        rr_grant_s = rr_grant_s;
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant_valid_s = rr_found_s;
      grant_s       = rr_grant_s;
    end else begin
      grant_valid_s = sel_ok_s;
      grant_s       = s;
    end
  end

  always_comb begin
    load_en_s = ~out_valid_q | out_ready;
    if (!rst && load_en_s && grant_valid_s) begin
      in_ready_s = N'(1'b1) << grant_s;
    end else begin
      in_ready_s = '0;
    end
  end

  // Next output register contents; everything holds while stalled.
  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en_s) begin
      if (grant_valid_s) begin
        out_d       = in[int'(grant_s)*W +: W];
        out_ch_d    = grant_s;
        out_valid_d = 1'b1;
        if (mode) begin
          ptr_d = grant_s;
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_s;

`ifdef MUX_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts output handshakes, wrapping naturally at 16 bits.
  always_comb begin
    if (out_valid_q && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: an N=4 and an N=3 instance against a behavioural model.
module tb_mux_nx1_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst;
  logic [15:0] in4;
  logic [3:0]  v4, irdy4, out4;
  logic        mode4, ov4, or4;
  logic [1:0]  s4, ch4;
  logic [11:0] in3;
  logic [2:0]  v3, irdy3;
  logic [3:0]  out3;
  logic        mode3, ov3, or3;
  logic [1:0]  s3, ch3;
`ifdef MUX_CNT_EN
  logic [15:0] cnt4, cnt3;
`endif

  mux_nx1_rr #(.W(4), .N(4)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .in_valid(v4), .in_ready(irdy4),
    .mode(mode4), .s(s4), .out(out4), .out_valid(ov4), .out_ready(or4), .out_ch(ch4)
`ifdef MUX_CNT_EN
    , .xfer_cnt(cnt4)
`endif
  );

  mux_nx1_rr #(.W(4), .N(3)) dut3 (
    .clk(clk), .rst(rst), .in(in3), .in_valid(v3), .in_ready(irdy3),
    .mode(mode3), .s(s3), .out(out3), .out_valid(ov3), .out_ready(or3), .out_ch(ch3)
`ifdef MUX_CNT_EN
    , .xfer_cnt(cnt3)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model state per instance (0: N=4, 1: N=3)
  logic [3:0]  m_out[2];
  int          m_ch[2];
  logic        m_val[2];
  int          m_ptr[2];
  logic [15:0] m_cnt[2];

  function automatic int grant_of(input int n, input logic md, input int sv,
                                  input logic [3:0] v, input int ptr);
    if (!md) return (sv < n && v[sv]) ? sv : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int i, input int n, input logic r, input logic md,
                            input int sv, input logic [3:0] v, input logic [15:0] din,
                            input logic rdy, input logic [3:0] a_out, input int a_ch,
                            input logic a_val, input logic [3:0] a_irdy);
    int g;
    logic le;
    logic [3:0] exp_r;
    if (r) begin
      m_out[i] = 4'h0; m_ch[i] = 0; m_val[i] = 1'b0; m_ptr[i] = n - 1; m_cnt[i] = 16'h0;
    end
    chk($sformatf("m%0d_out", i), a_out, m_out[i]);
    chk($sformatf("m%0d_ch", i), a_ch, m_ch[i]);
    chk($sformatf("m%0d_valid", i), a_val, m_val[i]);
`ifdef MUX_CNT_EN
    chk($sformatf("m%0d_cnt", i), (i == 0) ? cnt4 : cnt3, m_cnt[i]);
`endif
    g = grant_of(n, md, sv, v, m_ptr[i]);
    le = !m_val[i] || rdy;
    exp_r = (!r && le && g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk($sformatf("m%0d_in_ready", i), a_irdy, exp_r);
    if (!r) begin
      if (m_val[i] && rdy) m_cnt[i] = m_cnt[i] + 16'd1;
      if (le) begin
        if (g >= 0) begin
          m_out[i] = din[g*4 +: 4];
          m_ch[i]  = g;
          m_val[i] = 1'b1;
          if (md) m_ptr[i] = g;
        end else begin
          m_val[i] = 1'b0;
        end
      end
    end
  endtask

  // Compare both instances against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      model_step(0, 4, rst, mode4, int'(s4), v4, in4, or4, out4, int'(ch4), ov4, irdy4);
      model_step(1, 3, rst, mode3, int'(s3), {1'b0, v3}, {4'h0, in3}, or3, out3,
                 int'(ch3), ov3, {1'b0, irdy3});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int rr2_exp[4] = '{3, 0, 3, 0};
  logic rdy_pat[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; in4 = 16'h0; v4 = 4'h0; mode4 = 1'b0; s4 = 2'd0; or4 = 1'b0;
    in3 = 12'h0; v3 = 3'h0; mode3 = 1'b0; s3 = 2'd0; or3 = 1'b0;
    tick(); tick();
    chk("rst_out", out4, 4'h0);
    chk("rst_valid", ov4, 1'b0);
    chk("rst_in_ready", irdy4, 4'h0);

    // Steered select
    mode4 = 1'b0; s4 = 2'd2; v4 = 4'b0100; in4 = 16'h0A00; or4 = 1'b1; rst = 1'b0;
    #1;
    chk("sel_in_ready", irdy4, 4'b0100);
    tick();
    chk("sel_out", out4, 4'hA);
    chk("sel_ch", ch4, 2'd2);
    chk("sel_valid", ov4, 1'b1);

    // Back-pressure while in_valid[1] toggles
    or4 = 1'b0; s4 = 2'd1; in4 = 16'h0A50; v4 = 4'b0010;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", irdy4, 4'h0);
      chk("bp_out", out4, 4'hA);
      chk("bp_ch", ch4, 2'd2);
      tick();
      v4 = v4 ^ 4'b0010;
    end
    v4 = 4'b0010; or4 = 1'b1;
    #1;
    chk("bp_release_in_ready", irdy4, 4'b0010);
    tick();
    chk("bp_release_out", out4, 4'h5);
    chk("bp_release_ch", ch4, 2'd1);

    // Round-robin, all valid, then only channels 0 and 3
    rst = 1'b1;
    tick();
    in4 = 16'h4321; v4 = 4'b1111; mode4 = 1'b1; or4 = 1'b1; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_ch", ch4, rr_exp[i]);
      chk("rr_out", out4, rr_exp[i] + 1);
    end
    v4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr2_ch", ch4, rr2_exp[i]);
      chk("rr2_out", out4, rr2_exp[i] + 1);
    end

    // Mid-stream reset while stalled
    or4 = 1'b0; v4 = 4'b0110;
    tick();
    chk("mid_held_valid", ov4, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov4, 1'b0);
    chk("mid_rst_out", out4, 4'h0);
    chk("mid_rst_ch", ch4, 2'd0);
    chk("mid_rst_in_ready", irdy4, 4'h0);
    tick();
    rst = 1'b0; or4 = 1'b1;
    tick();
    chk("mid_first_ch", ch4, 2'd1);
    chk("mid_first_out", out4, 4'h2);
    chk("mid_first_valid", ov4, 1'b1);

    // N=3: select 3 is out of range
    s3 = 2'd0; v3 = 3'b111; in3 = 12'h321; or3 = 1'b1;
    tick();
    chk("n3_valid", ov3, 1'b1);
    chk("n3_ch", ch3, 2'd0);
    chk("n3_out", out3, 4'h1);
    s3 = 2'd3; or3 = 1'b0;
    #1;
    chk("n3_bad_in_ready_stall", irdy3, 3'b000);
    tick();
    chk("n3_hold_valid", ov3, 1'b1);
    chk("n3_hold_out", out3, 4'h1);
    or3 = 1'b1;
    #1;
    chk("n3_bad_in_ready", irdy3, 3'b000);
    tick();
    chk("n3_drain_valid", ov3, 1'b0);

`ifdef MUX_CNT_EN
    // Five output handshakes with stalls interleaved
    rst = 1'b1;
    tick();
    mode4 = 1'b1; v4 = 4'b1111; or4 = 1'b0; rst = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      or4 = rdy_pat[i];
      tick();
    end
    or4 = 1'b0;
    #1;
    chk("cnt_five", cnt4, 16'd5);

    // Wrap 0xFFFF -> 0x0000
    rst = 1'b1;
    tick();
    v4 = 4'b1111; or4 = 1'b1; rst = 1'b0;
    repeat (65536) tick();
    or4 = 1'b0;
    #1;
    chk("cnt_ffff", cnt4, 16'hFFFF);
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    #1;
    chk("cnt_wrap", cnt4, 16'h0000);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
